fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_checker.sv | 53 +++++
 rtl/fifo_reader.sv | 103 ++++++++++
 tb/tb_fifo_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: FSM state encoding, default
// parameter values and counter widths.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SEED   = 10;
    localparam int WORD_CNT_W = 16;
    localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/fifo_rd_checker.sv
// Sequence checker: tracks the expected next word, flags popped words that
// break the +1 sequence and keeps a saturating mismatch count.
module fifo_rd_checker
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEED  = DEF_SEED
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_err_clr,
    output logic                 o_mismatch,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_err_flag
);

    logic [WIDTH-1:0]     r_expected;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_flag;
    logic                 w_mismatch;

    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign w_mismatch = i_pop && (i_data != r_expected);

    // After every pop the next expected word follows the popped one, which
    // also resynchronises the sequence after a mismatch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_expected <= WIDTH'(SEED);
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (i_pop)
                r_expected <= i_data + WIDTH'(1);
            if (w_mismatch)
                r_err_cnt <= sat_inc_err(r_err_cnt);
            if (i_err_clr)
                r_err_flag <= 1'b0;
            else if (w_mismatch)
                r_err_flag <= 1'b1;
        end
    end

    assign o_mismatch = w_mismatch;
    assign o_err_cnt  = r_err_cnt;
    assign o_err_flag = r_err_flag;

endmodule

// File: rtl/fifo_reader.sv
// Show-ahead FIFO reader with a one-word output register and valid/ready
// handshake. Optional sequence checking is built when FIFO_READER_CHECK_EN is defined.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEED  = DEF_SEED
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  err_flag
);

    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_valid;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic                  w_pop;
    logic                  w_mismatch;

    function automatic logic [WORD_CNT_W-1:0] sat_inc_word(input logic [WORD_CNT_W-1:0] v);
        return (&v) ? v : v + WORD_CNT_W'(1);
    endfunction

    // Pop only when the output register is free or being emptied this cycle.
    assign w_pop = reset && (r_state == ST_RUN) && en && !fifo_empty
                   && (!r_out_valid || out_ready);

`ifdef FIFO_READER_CHECK_EN
    fifo_rd_checker #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_checker (
        .i_clk      (rd_clk),
        .i_rst_n    (reset),
        .i_pop      (w_pop),
        .i_data     (fifo_data),
        .i_err_clr  (err_clr),
        .o_mismatch (w_mismatch),
        .o_err_cnt  (err_cnt),
        .o_err_flag (err_flag)
    );
`else
    assign w_mismatch = 1'b0;
    assign err_cnt    = '0;
    assign err_flag   = 1'b0;
`endif

    always_ff @(posedge rd_clk) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (en) w_next_state = ST_RUN;
            ST_RUN: begin
                if (w_mismatch)
                    w_next_state = ST_ERR;
                else if (!en && !r_out_valid)
                    w_next_state = ST_IDLE;
            end
            ST_ERR:  if (err_clr) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_out_data  <= fifo_data;
                r_out_valid <= 1'b1;
                r_word_cnt  <= sat_inc_word(r_word_cnt);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = w_pop;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus randomized
// traffic compared each cycle against a behavioural model.
module tb_fifo_reader;

    localparam int WIDTH = 8;
    localparam int SEED  = 10;
`ifdef FIFO_READER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        rd_clk = 1'b0;
    logic        reset, en, fifo_empty, fifo_rd_en, out_valid, out_ready, err_clr, err_flag;
    logic [7:0]  fifo_data, out_data, err_cnt;
    logic [15:0] word_cnt;

    fifo_reader #(.WIDTH(WIDTH), .SEED(SEED)) dut (
        .rd_clk     (rd_clk),
        .reset      (reset),
        .en         (en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt),
        .err_flag   (err_flag)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;

    // FIFO contents and reference model (0=idle, 1=run, 2=error hold)
    logic [7:0] q[$];
    int m_state, m_ov, m_od, m_wc, m_ec, m_ef, m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic tick();
        bit mpop, mm;
        int d, ns;
        drive_fifo();
        #2;
        mpop = reset && (m_state == 1) && en && (q.size() > 0) && (m_ov == 0 || out_ready);
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, mpop});
        @(posedge rd_clk);
        if (!reset) begin
            m_state = 0; m_ov = 0; m_od = 0; m_wc = 0; m_ec = 0; m_ef = 0; m_exp = SEED;
        end else begin
            d  = mpop ? int'(q[0]) : 0;
            mm = CHK && mpop && (d != m_exp);
            ns = m_state;
            case (m_state)
                0: if (en) ns = 1;
                1: if (mm) ns = 2; else if (!en && m_ov == 0) ns = 0;
                default: if (err_clr) ns = 0;
            endcase
            if (mpop) begin
                m_od  = d;
                m_ov  = 1;
                m_wc  = (m_wc == 65535) ? m_wc : m_wc + 1;
                m_exp = (d + 1) % 256;
                void'(q.pop_front());
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (mm) m_ec = (m_ec == 255) ? m_ec : m_ec + 1;
            if (CHK) begin
                if (err_clr) m_ef = 0;
                else if (mm) m_ef = 1;
            end
            m_state = ns;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, m_ov);
        chk("out_data", {24'd0, out_data}, m_od);
        chk("word_cnt", {16'd0, word_cnt}, m_wc);
        chk("err_cnt", {24'd0, err_cnt}, m_ec);
        chk("err_flag", {31'd0, err_flag}, m_ef);
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        q.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int lp, guard;
        reset = 1'b0; en = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        m_state = 0; m_ov = 0; m_od = 0; m_wc = 0; m_ec = 0; m_ef = 0; m_exp = SEED;

        // Reset state
        do_reset();
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);

        // Empty FIFO with en=1: never pops
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("empty_valid", {31'd0, out_valid}, 0);

        // Back-to-back 10,11,12
        do_reset();
        q = '{8'd10, 8'd11, 8'd12};
        en = 1'b1; out_ready = 1'b1;
        tick();
        tick(); chk("seq_d0", {24'd0, out_data}, 10);
        tick(); chk("seq_d1", {24'd0, out_data}, 11);
        tick(); chk("seq_d2", {24'd0, out_data}, 12);
        chk("seq_wc", {16'd0, word_cnt}, 3);
        chk("seq_ec", {24'd0, err_cnt}, 0);
        tick();

        // Backpressure holds word 10, resumes with 11
        do_reset();
        q = '{8'd10, 8'd11, 8'd12};
        en = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_data", {24'd0, out_data}, 10);
        end
        out_ready = 1'b1;
        tick(); chk("resume_data", {24'd0, out_data}, 11);
        tick(); tick();

        // Sequence break 10,11,99,100
        do_reset();
        q = '{8'd10, 8'd11, 8'd99, 8'd100};
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("brk_data", {24'd0, out_data}, 99);
        chk("brk_ec", {24'd0, err_cnt}, CHK ? 1 : 0);
        chk("brk_ef", {31'd0, err_flag}, CHK ? 1 : 0);
        for (int i = 0; i < 3; i++) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_ef", {31'd0, err_flag}, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("after_clr_data", {24'd0, out_data}, 100);
        chk("after_clr_ec", {24'd0, err_cnt}, CHK ? 1 : 0);

        // En drop with a pending word: word still delivered, no more pops
        do_reset();
        q = '{8'd10, 8'd11, 8'd12};
        en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        chk("endrop_valid", {31'd0, out_valid}, 0);
        tick(); tick();
        chk("endrop_wc", {16'd0, word_cnt}, 1);

        // Wrap 10..255 then 0 with random backpressure
        do_reset();
        for (int v = 10; v <= 255; v++) q.push_back(8'(v));
        q.push_back(8'd0);
        en = 1'b1;
        guard = 0;
        while ((q.size() != 0 || m_ov != 0) && guard < 2000) begin
            out_ready = ($urandom_range(0, 99) < 75);
            tick();
            guard++;
        end
        chk("wrap_timeout", guard < 2000, 1);
        chk("wrap_last", {24'd0, out_data}, 0);
        chk("wrap_wc", {16'd0, word_cnt}, 247);
        chk("wrap_ec", {24'd0, err_cnt}, 0);

        // Randomized traffic
        do_reset();
        lp = SEED - 1;
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) >= 2);
            en        = ($urandom_range(0, 99) < 85);
            out_ready = ($urandom_range(0, 99) < 70);
            err_clr   = ($urandom_range(0, 99) < 6);
            if (q.size() < 8 && $urandom_range(0, 99) < 60) begin
                lp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : (lp + 1) % 256;
                q.push_back(8'(lp));
            end
            tick();
        end
        reset = 1'b1; err_clr = 1'b0;

        // Reset while a word is held
        do_reset();
        q = '{8'd10, 8'd11};
        en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_wc", {16'd0, word_cnt}, 0);
        chk("mid_rst_ef", {31'd0, err_flag}, 0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
